// File: rtl/dlx_ext_control_fsm.sv
// rtl/dlx_ext_control_fsm.sv - multicycle DLX control FSM with N start/done extension channels
// Purpose: sequences fetch/decode/execute of DLX instructions and drives datapath
//   strobes; dispatches extension-unit R-type ops via a start/done handshake,
//   halts on illegal opcodes and on bus/extension stall timeouts, and counts
//   legally decoded instructions.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   step_en, busy, AEQZ   run control, memory busy, A==0 flag
//   IR                    instruction register
//   ext_done/ext_start/ext_sel  per-channel handshake and one-hot select
//   mr..in_init, S1_sel, S2_sel datapath strobes and ALU operand selects
//   state_out, halt_cause, instr_count  status
module dlx_ext_control_fsm #(
  parameter int N_EXT         = 2,
  parameter int EXT_FUNC_BASE = 6'h38,
  parameter int BUS_TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             busy,
  input  logic             AEQZ,
  input  logic [31:0]      IR,
  input  logic [N_EXT-1:0] ext_done,
  output logic [N_EXT-1:0] ext_start,
  output logic [N_EXT-1:0] ext_sel,
  output logic             mr, mw, IR_en, PC_en, A_en, B_en, C_en, MAR_en, MDR_en,
  output logic             MDR_sel, GPR_WE, Itype, test, shift, right, jlink, add,
  output logic             A_sel, DINT_sel, in_init,
  output logic [1:0]       S1_sel,
  output logic [1:0]       S2_sel,
  output logic [4:0]       state_out,
  output logic [1:0]       halt_cause,
  output logic [31:0]      instr_count
);

  typedef enum logic [4:0] {
    INIT = 5'd0, FETCH = 5'd1, DECODE = 5'd2, HALT = 5'd3, ALU = 5'd4, SHIFT = 5'd5,
    WBR = 5'd6, ALUI = 5'd7, WBI = 5'd8, TESTI = 5'd9, ADDRCMP = 5'd10, LOAD = 5'd11,
    COPYMDR2C = 5'd12, COPYGPR2MDR = 5'd13, STORE = 5'd14, JR = 5'd15, SAVEPC = 5'd16,
    JALR = 5'd17, BRANCH = 5'd18, BTAKEN = 5'd19, EXT_START = 5'd20, EXT_WAIT = 5'd21
  } state_t;

  localparam logic [6:0] EXT_LO   = 7'(EXT_FUNC_BASE);
  localparam logic [6:0] EXT_HI   = 7'(EXT_FUNC_BASE + N_EXT);
  localparam logic [7:0] STALL_MAX = 8'(BUS_TIMEOUT - 1);

  state_t      state, state_d;
  logic [1:0]  k, k_d;
  logic [7:0]  stall_cnt;
  logic [1:0]  cause_d;
  logic [31:0] instr_count_d;
  logic [N_EXT-1:0] k_onehot;
  logic        done_k, stall, timed_out, is_ext;
  logic [6:0]  func7;
  state_t      next_instr;
  logic        unused_ir;

  assign unused_ir  = ^IR[25:6];
  assign func7      = {1'b0, IR[5:0]};
  assign is_ext     = (IR[31:26] == 6'b0) && (func7 >= EXT_LO) && (func7 < EXT_HI);
  assign next_instr = step_en ? FETCH : INIT;
  assign state_out  = state;

  // Only the selected channel's done is observed; other channels are ignored.
  always_comb begin
    k_onehot = '0;
    done_k   = 1'b0;
    for (int i = 0; i < N_EXT; i++) begin
      if (k == 2'(i)) begin
        k_onehot[i] = 1'b1;
        done_k      = ext_done[i];
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      FETCH, LOAD, STORE: stall = busy;
      EXT_WAIT:           stall = ~done_k;
      default:            stall = 1'b0;
    endcase
  end

  assign timed_out = stall && (stall_cnt == STALL_MAX);

  always_comb begin
    state_d = state;
    k_d     = k;
    cause_d = 2'b00;
    case (state)
      INIT:      if (step_en) state_d = FETCH;
      FETCH: begin
        if (!busy) state_d = DECODE;
        else if (timed_out) begin state_d = HALT; cause_d = 2'b10; end
      end
      DECODE: begin
        if (IR[31:29] == 3'b110) state_d = next_instr;
        else if (is_ext) begin
          state_d = EXT_START;
          k_d     = 2'(func7 - EXT_LO);
        end
        else if (IR[31:28] == 4'b0000) state_d = IR[5] ? ALU : SHIFT;
        else if (IR[31:29] == 3'b001) state_d = ALUI;
        else if (IR[31:29] == 3'b011) state_d = TESTI;
        else if (IR[31:30] == 2'b10)  state_d = ADDRCMP;
        else if (IR[31:29] == 3'b010) state_d = IR[26] ? SAVEPC : JR;
        else if (IR[31:28] == 4'b0001) state_d = BRANCH;
        else begin state_d = HALT; cause_d = 2'b01; end
      end
      EXT_START: state_d = EXT_WAIT;
      EXT_WAIT: begin
        if (done_k) state_d = WBR;
        else if (timed_out) begin state_d = HALT; cause_d = 2'b11; end
      end
      ALU, SHIFT:  state_d = WBR;
      ALUI, TESTI: state_d = WBI;
      ADDRCMP:     state_d = IR[29] ? COPYGPR2MDR : LOAD;
      COPYGPR2MDR: state_d = STORE;
      LOAD: begin
        if (!busy) state_d = COPYMDR2C;
        else if (timed_out) begin state_d = HALT; cause_d = 2'b10; end
      end
      COPYMDR2C: state_d = WBI;
      SAVEPC:    state_d = JALR;
      BRANCH:    state_d = (AEQZ ^ IR[26]) ? BTAKEN : next_instr;
      WBR, WBI, BTAKEN, JR, JALR: state_d = next_instr;
      STORE: begin
        if (!busy) state_d = next_instr;
        else if (timed_out) begin state_d = HALT; cause_d = 2'b10; end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  assign instr_count_d = (state == DECODE && state_d != HALT) ? instr_count + 32'd1 : instr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      k           <= 2'b00;
      stall_cnt   <= 8'd0;
      halt_cause  <= 2'b00;
      instr_count <= 32'd0;
    end else begin
      state       <= state_d;
      k           <= k_d;
      instr_count <= instr_count_d;
      if (state_d != state) stall_cnt <= 8'd0;
      else if (stall)       stall_cnt <= stall_cnt + 8'd1;
      if (state != HALT && state_d == HALT && halt_cause == 2'b00)
        halt_cause <= cause_d;
    end
  end

  always_comb begin
    {mr, mw, IR_en, PC_en, A_en, B_en, C_en, MAR_en, MDR_en, MDR_sel} = '0;
    {GPR_WE, Itype, test, shift, right, jlink, add, A_sel, DINT_sel, in_init} = '0;
    S1_sel    = 2'b00;
    S2_sel    = 2'b00;
    ext_start = '0;
    ext_sel   = '0;
    case (state)
      INIT, HALT: in_init = 1'b1;
      FETCH:      begin mr = 1'b1; IR_en = 1'b1; end
      DECODE:     begin A_en = 1'b1; B_en = 1'b1; PC_en = 1'b1; add = 1'b1; S2_sel = 2'b11; end
      ALU:        begin C_en = 1'b1; S1_sel = 2'b01; end
      SHIFT:      begin C_en = 1'b1; shift = 1'b1; DINT_sel = 1'b1; right = IR[1]; S1_sel = 2'b01; end
      ALUI:       begin C_en = 1'b1; Itype = 1'b1; add = 1'b1; S1_sel = 2'b01; S2_sel = 2'b01; end
      TESTI:      begin C_en = 1'b1; Itype = 1'b1; test = 1'b1; S1_sel = 2'b01; S2_sel = 2'b01; end
      WBR:        GPR_WE = 1'b1;
      WBI:        begin GPR_WE = 1'b1; Itype = 1'b1; end
      ADDRCMP:    begin MAR_en = 1'b1; add = 1'b1; S1_sel = 2'b01; S2_sel = 2'b01; end
      LOAD:       begin mr = 1'b1; MDR_sel = 1'b1; A_sel = 1'b1; MDR_en = ~busy; end
      COPYMDR2C:  begin C_en = 1'b1; DINT_sel = 1'b1; S1_sel = 2'b11; S2_sel = 2'b10; end
      COPYGPR2MDR: begin MDR_en = 1'b1; DINT_sel = 1'b1; S1_sel = 2'b10; S2_sel = 2'b10; end
      STORE:      begin mw = 1'b1; A_sel = 1'b1; end
      JR:         begin PC_en = 1'b1; add = 1'b1; S1_sel = 2'b01; S2_sel = 2'b10; end
      SAVEPC:     begin C_en = 1'b1; add = 1'b1; S2_sel = 2'b10; end
      JALR:       begin PC_en = 1'b1; add = 1'b1; jlink = 1'b1; GPR_WE = 1'b1; S1_sel = 2'b01; S2_sel = 2'b10; end
      BTAKEN:     begin PC_en = 1'b1; add = 1'b1; S2_sel = 2'b01; end
      EXT_START:  begin ext_start = k_onehot; ext_sel = k_onehot; end
      EXT_WAIT:   begin ext_sel = k_onehot; C_en = done_k; end
      default:    in_init = 1'b0;
    endcase
  end

endmodule
